if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Decoupling fetch queue between the fetch stage and the decode stage. Captures
//  each fetched {pc, instr} pair with a valid/ready handshake and presents entries
//  in order to decode, which is first-word-fall-through. in_ready drives the fetch
//  stage's pc_write; flush squashes wrong-path instructions on a taken branch.
// PARAMETERS
//  DEPTH  2   number of entries; power of two, >= 2
//  XLEN   32  width of pc and instr fields
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset asserted)
//  in_valid   in   1      fetch presents a valid {in_pc, in_instr}
//  in_pc      in   XLEN   pc of the fetched instruction
//  in_instr   in   XLEN   fetched instruction word
//  in_ready   out  1      queue accepts a push this cycle (= !full)
//  flush      in   1      squash all queued entries (branch taken / redirect)
//  out_valid  out  1      head entry valid (= count != 0)
//  out_pc     out  XLEN   head pc; 0 when out_valid=0
//  out_instr  out  XLEN   head instr; 32'h00000013 (NOP) when out_valid=0
//  out_ready  in   1      decode consumes the head this cycle
//  count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  stall_cnt  out  32     perf: cycles with in_valid & !in_ready (see CONFIG)
//  flush_cnt  out  32     perf: entries discarded by flush (see CONFIG)
// BEHAVIOUR
//  - Storage: DEPTH-entry circular buffer; wr_ptr/rd_ptr carry one extra wrap bit;
//    full = ptr MSBs differ and low bits equal; empty = ptrs equal.
//  - Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=0
//    while reset is asserted, then 1 on the first cycle after deassertion;
//    out_pc=0, out_instr=NOP, stall_cnt=flush_cnt=0. Reset mid-operation drops all
//    entries immediately; no partial push survives.
//  - Push: in_valid & in_ready at the rising edge -> write entry at wr_ptr, wr_ptr++.
//  - Pop: out_valid & out_ready at the rising edge -> rd_ptr++.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N
//    (1 cycle); no combinational in->out bypass when the queue is empty.
//  - in_ready depends only on registered state (!full), never on out_ready; when
//    full, a same-cycle pop does NOT enable a push (no fall-through), so the
//    fetch-to-decode path has no combinational loop.
//  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both
//    pointers advance.
//  - Pointer wrap: pointers wrap modulo 2*DEPTH; entry index = ptr[log2(DEPTH)-1:0].
//  - Flush has priority: pointers reset to 0, count -> 0 next cycle, and a push or
//    pop in the same cycle is ignored. out_valid=0 on the cycle after flush.
//  - out_ready while out_valid=0 is ignored (no underflow).
//  - in_valid while in_ready=0: no write; fetch holds the PC via pc_write=0.
// CONFIGURATION
//  IF_ID_PERF_EN defined: stall_cnt increments each cycle with in_valid & !in_ready
//    & reset=1; flush_cnt adds the current count on each flush cycle; both are
//    32-bit and wrap modulo 2^32; async-cleared by reset.
//  IF_ID_PERF_EN undefined: no counter logic; stall_cnt and flush_cnt tied to 0.
// TESTING
//  1 Reset: hold reset=0 with in_valid=1 -> count=0, out_valid=0, out_instr=
//    32'h00000013, in_ready=0; release -> in_ready=1 next cycle.
//  2 Fill (DEPTH=2, out_ready=0): push pc 0x0, 0x4 -> count=2, in_ready=0; push of
//    0x8 is held; out_pc=0x0.
//  3 Full with pop: count=2, out_ready=1, in_valid=1 (0x8) -> pop 0x0 only, count=1;
//    0x8 accepted the following cycle; output order is 0x0, 0x4, 0x8.
//  4 Wrap: stream 10 instrs pc 0x0..0x24 with out_ready toggling 1/0 -> decode
//    sees all 10 in order, none duplicated or lost.
//  5 Flush: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0,
//    out_valid=0, no pop counted; flush_cnt += 2 when IF_ID_PERF_EN is defined, else 0.
//  6 Async reset mid-stream: drop reset between edges with count=1 -> out_valid=0
//    immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//   Decoupling fetch queue between fetch and decode. Fetch pushes {pc, instr}
//   with a valid/ready handshake; decode sees the head entry first-word-fall-
//   through style one cycle after it was pushed. Flush squashes all entries.
//
//   All flow-control and head outputs are registered from next-state logic, so
//   in_ready never depends combinationally on out_ready.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   fetch presents {in_pc, in_instr}
//   in_pc      pc of fetched instruction
//   in_instr   fetched instruction word
//   in_ready   queue accepts a push this cycle (!full)
//   flush      squash every queued entry
//   out_valid  head entry valid
//   out_pc     head pc (0 when empty)
//   out_instr  head instr (NOP when empty)
//   out_ready  decode consumes the head
//   count      occupancy 0..DEPTH
//   stall_cnt  perf: cycles with in_valid & !in_ready
//   flush_cnt  perf: entries discarded by flush
//
// Configuration
//   IF_ID_PERF_EN  defined: perf counters implemented; undefined: tied to 0.
// ----------------------------------------------------------------------------
module if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic            full_d;
    logic            push;
    logic            pop;

    // Next-state: pointers, occupancy and the registered head view.
    always_comb begin
        push        = in_valid & in_ready_q & ~flush;
        pop         = out_valid_q & out_ready & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_pc_d    = '0;
        out_instr_d = NOP;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d     = wr_ptr_d - rd_ptr_d;
        full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        in_ready_d  = ~full_d;
        out_valid_d = (wr_ptr_d != rd_ptr_d);

        // The entry being written this cycle becomes the head when the read
        // pointer lands on the slot being written; memory is not updated yet.
        if (out_valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_pc_d    = in_pc;
                out_instr_d = in_instr;
            end else begin
                out_pc_d    = mem_pc[rd_ptr_d[AW-1:0]];
                out_instr_d = mem_instr[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    // Entry storage; contents are meaningless until pointed to, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q[AW-1:0]]    <= in_pc;
            mem_instr[wr_ptr_q[AW-1:0]] <= in_instr;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign count     = count_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Perf counters; wrap modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready_q) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)                   flush_cnt_q <= flush_cnt_q + 32'(count_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2, XLEN=32).
module tb_if_id_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
`ifdef IF_ID_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            flush;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;
    logic [1:0]      count;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;

    int tests  = 0;
    int failed = 0;

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hA5C3, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    initial begin
        int sent;
        int got;
        bit tog;

        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive_push(32'h100);

        // Reset held with in_valid asserted.
        step(); step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);

        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("release_ready_pre", 64'(in_ready), 64'd0);
        step();
        check("release_ready", 64'(in_ready), 64'd1);
        check("release_empty", 64'(out_valid), 64'd0);

        // Fill with decode stalled.
        drive_push(32'h0);
        step();
        check("fill1_count", 64'(count), 64'd1);
        check("fill1_valid", 64'(out_valid), 64'd1);
        check("fill1_instr", 64'(out_instr), 64'(instr_of(32'h0)));
        drive_push(32'h4);
        step();
        check("fill2_count", 64'(count), 64'd2);
        check("fill2_ready", 64'(in_ready), 64'd0);
        drive_push(32'h8);
        step();
        check("held_count", 64'(count), 64'd2);
        check("held_pc", 64'(out_pc), 64'h0);

        // Full with pop: only the pop happens.
        out_ready = 1'b1;
        step();
        check("fullpop_count", 64'(count), 64'd1);
        check("fullpop_pc", 64'(out_pc), 64'h4);
        check("fullpop_ready", 64'(in_ready), 64'd1);
        check("stall_cnt", 64'(stall_cnt), PERF ? 64'd2 : 64'd0);
        step();
        check("push8_count", 64'(count), 64'd1);
        check("push8_pc", 64'(out_pc), 64'h8);
        check("push8_instr", 64'(out_instr), 64'(instr_of(32'h8)));
        in_valid = 1'b0;
        step();
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_pc", 64'(out_pc), 64'd0);
        check("drain_instr", 64'(out_instr), 64'h13);

        // Stream 10 with decode toggling ready; pointers wrap repeatedly.
        sent = 0; got = 0; tog = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_pc     = 32'(sent * 4);
            in_instr  = instr_of(32'(sent * 4));
            out_ready = tog;
            if (out_valid && out_ready) begin
                check("stream_pc", 64'(out_pc), 64'(got * 4));
                check("stream_instr", 64'(out_instr), 64'(instr_of(32'(got * 4))));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
            tog = ~tog;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_got", 64'(got), 64'd10);
        check("stream_empty", 64'(count), 64'd0);

        // Flush beats simultaneous push and pop.
        drive_push(32'h40);
        step();
        drive_push(32'h44);
        step();
        check("preflush_count", 64'(count), 64'd2);
        check("preflush_pc", 64'(out_pc), 64'h40);
        flush = 1'b1; out_ready = 1'b1;
        drive_push(32'h48);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_cnt", 64'(flush_cnt), PERF ? 64'd2 : 64'd0);
        step();
        check("postflush_valid", 64'(out_valid), 64'd0);

        // Async reset between edges.
        drive_push(32'h80);
        step();
        in_valid = 1'b0;
        check("pre_async_count", 64'(count), 64'd1);
        check("pre_async_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_count", 64'(count), 64'd0);
        check("async_ready", 64'(in_ready), 64'd0);
        check("async_instr", 64'(out_instr), 64'h13);
        reset = 1'b1;
        step();
        check("post_async_ready", 64'(in_ready), 64'd1);
        check("post_async_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
